// File: rtl/line_word_access.sv
// Word read from a cache line buffer: fetches the base line, and the next line when the
// masked bytes run past the line end, then returns the assembled word over valid/ready.
module line_word_access #(
  parameter int unsigned LINE_W = 128,
  parameter int unsigned WORD_W = 16,
  localparam int unsigned LB    = LINE_W / 8,
  localparam int unsigned WB    = WORD_W / 8,
  localparam int unsigned OFS_W = $clog2(LB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OFS_W-1:0]  req_offset,
  input  logic [WB-1:0]     req_mask,
  output logic              line_req,
  output logic              line_sel,
  input  logic              line_resp,
  input  logic [LINE_W-1:0] line_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch0,
    StFetch1,
    StResp
  } state_e;

  state_e              state_q;
  logic [OFS_W-1:0]    offset_q;
  logic [WB-1:0]       mask_q;
  logic                span_q;
  logic [WORD_W-1:0]   data_q;
  logic                err_q;
  logic                req_ready_q;
  logic                line_req_q;
  logic                line_sel_q;
  logic                rsp_valid_q;

  logic [WB-1:0]       req_hi;
  logic [WB-1:0]       lat_hi;
  logic [WORD_W-1:0]   data_d;

  // Lane i lands in the next line when offset+i carries out of the OFS_W-bit byte index.
  function automatic logic lane_hi(input logic [OFS_W-1:0] ofs, input int unsigned i);
    logic [OFS_W:0] pos;
    pos = {1'b0, ofs} + (OFS_W+1)'(i);
    return pos[OFS_W];
  endfunction

  // Byte within whichever line holds lane i; the wrap gives offset+i-LB for next-line lanes.
  function automatic logic [OFS_W-1:0] lane_byte(input logic [OFS_W-1:0] ofs,
                                                 input int unsigned i);
    return ofs + OFS_W'(i);
  endfunction

  always_comb begin
    req_hi = '0;
    lat_hi = '0;
    data_d = data_q;
    for (int unsigned i = 0; i < WB; i++) begin
      req_hi[i] = lane_hi(req_offset, i);
      lat_hi[i] = lane_hi(offset_q, i);
      if (mask_q[i] && (lat_hi[i] == (state_q == StFetch1))) begin
        data_d[8*i +: 8] = line_data[{lane_byte(offset_q, i), 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      offset_q    <= '0;
      mask_q      <= '0;
      span_q      <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      line_req_q  <= 1'b0;
      line_sel_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            offset_q    <= req_offset;
            mask_q      <= req_mask;
            data_q      <= '0;
            err_q       <= 1'b0;
            span_q      <= |(req_mask & req_hi);
            req_ready_q <= 1'b0;
            if (req_mask == '0) begin
              state_q     <= StResp;
              err_q       <= 1'b1;
              rsp_valid_q <= 1'b1;
            end else if ((req_mask & ~req_hi) == '0) begin
              state_q    <= StFetch1;
              line_req_q <= 1'b1;
              line_sel_q <= 1'b1;
            end else begin
              state_q    <= StFetch0;
              line_req_q <= 1'b1;
              line_sel_q <= 1'b0;
            end
          end
        end
        StFetch0: begin
          if (line_resp) begin
            data_q <= data_d;
            if (span_q) begin
              state_q    <= StFetch1;
              line_sel_q <= 1'b1;
            end else begin
              state_q     <= StResp;
              line_req_q  <= 1'b0;
              line_sel_q  <= 1'b0;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        StFetch1: begin
          if (line_resp) begin
            data_q      <= data_d;
            state_q     <= StResp;
            line_req_q  <= 1'b0;
            line_sel_q  <= 1'b0;
            rsp_valid_q <= 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign line_req  = line_req_q;
  assign line_sel  = line_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

endmodule
